// File: rtl/master_reset_seq_pkg.sv
// Shared types, default parameter values and counter-width helpers for the
// master reset sequencer.
package master_reset_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ASSERT  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int unsigned DEF_NUM_CH       = 3;
  localparam int unsigned DEF_HOLD_CYCLES  = 10;
  localparam int unsigned DEF_PULSE_CYCLES = 4;
  localparam int unsigned DEF_STAGGER      = 2;
  localparam int unsigned DEF_SYNC_STAGES  = 2;
  localparam int unsigned DEF_EVT_W        = 8;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/master_reset_seq_if.sv
// Request/response bundle between the reset sources and the sequencer.
interface master_reset_seq_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned EVT_W  = 8
);
  logic              Req_L;
  logic [NUM_CH-1:0] Reset_L_Out;
  logic              Busy;
  logic              Armed;
  logic [EVT_W-1:0]  Event_Count;

  modport master (
    input  Req_L,
    output Reset_L_Out,
    output Busy,
    output Armed,
    output Event_Count
  );

  modport slave (
    output Req_L,
    input  Reset_L_Out,
    input  Busy,
    input  Armed,
    input  Event_Count
  );
endinterface

// File: rtl/master_reset_seq_reset_sync_bit.sv
// N-stage single-bit synchroniser; flops reset to 1 (request inactive).
module reset_sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the asynchronous input through the chain on the falling edge.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '1;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/master_reset_seq.sv
// Qualifies a soft-reset request and drives a multi-channel active-low reset
// pulse with staggered per-channel release. All state changes on the negedge.
module master_reset_seq
  import master_reset_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned STAGGER      = DEF_STAGGER,
  parameter int unsigned SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int unsigned EVT_W        = DEF_EVT_W
) (
  input  logic              CLK,
  input  logic              Reset_L,
  master_reset_seq_if.master bus
);

  localparam int unsigned HW = cnt_w(HOLD_CYCLES);
  localparam int unsigned PW = cnt_w(PULSE_CYCLES);
  localparam int unsigned SW = cnt_w(STAGGER);

  localparam logic [HW-1:0]     HOLD_MAX   = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0]     HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [PW-1:0]     PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [SW-1:0]     STAG_LAST  = SW'((STAGGER == 0) ? 0 : STAGGER - 1);
  localparam logic [NUM_CH-1:0] FIRST_CH   = NUM_CH'(1);
  // With no stagger or a single channel every output releases on RELEASE entry,
  // so the sequence goes straight from ASSERT back to IDLE.
  localparam bit                ONE_SHOT   = (STAGGER == 0) || (NUM_CH == 1);

  state_t            state;
  logic [NUM_CH-1:0] out_q;
  logic [NUM_CH-1:0] nxt_out;
  logic [HW-1:0]     hold_cnt;
  logic [PW-1:0]     pulse_cnt;
  logic [SW-1:0]     stag_cnt;
  logic [EVT_W-1:0]  event_cnt;
  logic              busy_q;
  logic              armed_q;
  logic              req_s;

  reset_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_req_sync (
    .clk   (CLK),
    .rst_n (Reset_L),
    .d     (bus.Req_L),
    .q     (req_s)
  );

  // Thermometer fill: the next channel above those already released.
  always_comb begin
    nxt_out = '0;
    nxt_out = (out_q << 1) | FIRST_CH;
  end

  // Sequencer FSM with registered outputs; reset enters ASSERT so power-on
  // behaves like a soft reset without counting an event.
  always_ff @(negedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= ASSERT;
      out_q     <= '0;
      hold_cnt  <= '0;
      pulse_cnt <= '0;
      stag_cnt  <= '0;
      event_cnt <= '0;
      busy_q    <= 1'b1;
      armed_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!req_s) begin
            if (hold_cnt != HOLD_MAX) begin
              hold_cnt <= hold_cnt + 1'b1;
            end
            if (hold_cnt == HOLD_LAST) begin
              state   <= ARMED;
              armed_q <= 1'b1;
            end
          end else begin
            hold_cnt <= '0;
          end
        end
        ARMED: begin
          if (req_s) begin
            state     <= ASSERT;
            out_q     <= '0;
            hold_cnt  <= '0;
            pulse_cnt <= '0;
            busy_q    <= 1'b1;
            armed_q   <= 1'b0;
            if (event_cnt != '1) begin
              event_cnt <= event_cnt + 1'b1;
            end
          end
        end
        ASSERT: begin
          hold_cnt <= '0;
          if (pulse_cnt == PULSE_LAST) begin
            pulse_cnt <= '0;
            stag_cnt  <= '0;
            if (ONE_SHOT) begin
              out_q  <= '1;
              state  <= IDLE;
              busy_q <= 1'b0;
            end else begin
              out_q <= FIRST_CH;
              state <= RELEASE;
            end
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        RELEASE: begin
          hold_cnt <= '0;
          if (stag_cnt == STAG_LAST) begin
            stag_cnt <= '0;
            out_q    <= nxt_out;
            if (&nxt_out) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            stag_cnt <= stag_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.Reset_L_Out = out_q;
  assign bus.Busy        = busy_q;
  assign bus.Armed       = armed_q;
  assign bus.Event_Count = event_cnt;

endmodule

// File: tb/tb_master_reset_seq.sv
// Bench for master_reset_seq: default configuration plus a corner instance,
// both checked every cycle against an age-based reference model.
module tb_master_reset_seq;

  localparam int unsigned P_NCH   [2] = '{3, 1};
  localparam int unsigned P_HOLD  [2] = '{10, 1};
  localparam int unsigned P_PULSE [2] = '{4, 4};
  localparam int unsigned P_STAG  [2] = '{2, 0};
  localparam int unsigned P_EVTMX [2] = '{255, 3};

  logic CLK     = 1'b1;
  logic Reset_L = 1'b1;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  master_reset_seq_if #(.NUM_CH(3), .EVT_W(8)) bus0 ();
  master_reset_seq_if #(.NUM_CH(1), .EVT_W(2)) bus1 ();

  master_reset_seq u_dut (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus0)
  );

  master_reset_seq #(
    .NUM_CH       (1),
    .HOLD_CYCLES  (1),
    .PULSE_CYCLES (4),
    .STAGGER      (0),
    .SYNC_STAGES  (2),
    .EVT_W        (2)
  ) u_cor (
    .CLK     (CLK),
    .Reset_L (Reset_L),
    .bus     (bus1)
  );

  always #5 CLK = ~CLK;

  // Reference model: a sequence is described by its age (edges since ASSERT
  // entry); channel c is high once age >= PULSE + c*STAGGER.
  bit          m_in_seq [2];
  bit          m_armed  [2];
  int unsigned m_age    [2];
  int unsigned m_low    [2];
  int unsigned m_evt    [2];
  logic [1:0]  m_pipe   [2];

  task automatic model_rst(int i);
    m_in_seq[i] = 1'b1;
    m_armed[i]  = 1'b0;
    m_age[i]    = 0;
    m_low[i]    = 0;
    m_evt[i]    = 0;
    m_pipe[i]   = 2'b11;
  endtask

  task automatic model_edge(int i, logic req, logic rst_l);
    logic rs;
    if (!rst_l) begin
      model_rst(i);
      return;
    end
    rs        = m_pipe[i][1];
    m_pipe[i] = {m_pipe[i][0], req};
    if (m_in_seq[i]) begin
      m_age[i]++;
      if (m_age[i] >= P_PULSE[i] + (P_NCH[i] - 1) * P_STAG[i]) m_in_seq[i] = 1'b0;
      m_low[i] = 0;
    end else if (m_armed[i]) begin
      if (rs) begin
        m_armed[i]  = 1'b0;
        m_in_seq[i] = 1'b1;
        m_age[i]    = 0;
        m_low[i]    = 0;
        if (m_evt[i] < P_EVTMX[i]) m_evt[i]++;
      end
    end else if (!rs) begin
      m_low[i]++;
      if (m_low[i] >= P_HOLD[i]) m_armed[i] = 1'b1;
    end else begin
      m_low[i] = 0;
    end
  endtask

  function automatic logic [31:0] exp_out(int i);
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < int'(P_NCH[i]); c++)
      r[c] = !m_in_seq[i] || (m_age[i] >= P_PULSE[i] + c * P_STAG[i]);
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("out0",   32'(bus0.Reset_L_Out), exp_out(0));
    chk("busy0",  32'(bus0.Busy),        32'(m_in_seq[0]));
    chk("armed0", 32'(bus0.Armed),       32'(m_armed[0]));
    chk("evt0",   32'(bus0.Event_Count), m_evt[0]);
    chk("out1",   32'(bus1.Reset_L_Out), exp_out(1));
    chk("busy1",  32'(bus1.Busy),        32'(m_in_seq[1]));
    chk("armed1", 32'(bus1.Armed),       32'(m_armed[1]));
    chk("evt1",   32'(bus1.Event_Count), m_evt[1]);
  endtask

  // Inputs change on the posedge; state moves on the negedge; check 1 later.
  task automatic cyc(logic rst_l, logic req);
    @(posedge CLK);
    Reset_L    = rst_l;
    bus0.Req_L = req;
    bus1.Req_L = req;
    @(negedge CLK);
    model_edge(0, req, rst_l);
    model_edge(1, req, rst_l);
    #1;
    chk_all();
  endtask

  initial begin
    logic v;
    int unsigned n;
    bus0.Req_L = 1'b1;
    bus1.Req_L = 1'b1;

    // Power-on: asynchronous reset takes effect without a clock edge.
    #1 Reset_L = 1'b0;
    model_rst(0);
    model_rst(1);
    #1 chk_all();
    repeat (3) cyc(1'b0, 1'b1);
    repeat (12) cyc(1'b1, 1'b1);

    // Glitch shorter than the hold window.
    n = $urandom_range(1, 9);
    repeat (n) cyc(1'b1, 1'b0);
    repeat (20) cyc(1'b1, 1'b1);

    // Qualified request, then a request held while the sequence is running.
    n = $urandom_range(12, 40);
    repeat (n) cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b1, 1'b1);
    repeat (12) cyc(1'b1, 1'b0);
    repeat (20) cyc(1'b1, 1'b1);

    // Async reset mid-RELEASE once only channel 0 is out of reset.
    repeat (15) cyc(1'b1, 1'b0);
    for (int k = 0; k < 60 && exp_out(0) != 32'h1; k++) cyc(1'b1, 1'b1);
    chk("wait001", 32'(bus0.Reset_L_Out), 32'h1);
    #2 Reset_L = 1'b0;
    model_rst(0);
    model_rst(1);
    #1 chk_all();
    repeat (3) cyc(1'b0, 1'b0);
    repeat (15) cyc(1'b1, 1'b1);

    // Random request activity.
    v = 1'b0;
    repeat (16) begin
      n = $urandom_range(1, 25);
      repeat (n) cyc(1'b1, v);
      v = ~v;
    end
    repeat (15) cyc(1'b1, 1'b1);

    // Five qualified requests: corner counter must saturate.
    repeat (5) begin
      repeat (12) cyc(1'b1, 1'b0);
      repeat (14) cyc(1'b1, 1'b1);
    end
    chk("cor_sat", 32'(bus1.Event_Count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
